// File: rtl/mem_bus_router_pkg.sv
// Shared types and constants for the memory bus router.
// Build option: MEM_BUS_ROUTER_ERR_EN enables the decode-error response path.
package mem_bus_pkg;

  localparam int ADDR_W      = 30;
  localparam int DATA_W      = 32;
  localparam int MAX_REGIONS = 8;

  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_bus_router_if.sv
// CPU-side and slave-side bus signals of the memory bus router.
// The slave modport is the router's view; master is the environment's view.
interface mem_bus_router_if #(
  parameter int N_REGIONS = 2
);
  import mem_bus_pkg::*;

  logic                          i_valid;
  logic                          o_ready;
  logic [ADDR_W-1:0]             i_addr;
  logic [DATA_W-1:0]             i_wdata;
  logic                          i_wren;
  logic [3:0]                    i_mask;
  logic                          o_rvalid;
  logic [DATA_W-1:0]             o_rdata;
  logic                          o_err;
  logic [N_REGIONS-1:0]          o_s_valid;
  logic [N_REGIONS-1:0]          i_s_ready;
  logic [N_REGIONS*ADDR_W-1:0]   o_s_addr;
  logic [DATA_W-1:0]             o_s_wdata;
  logic                          o_s_wren;
  logic [3:0]                    o_s_mask;
  logic [N_REGIONS-1:0]          i_s_rvalid;
  logic [N_REGIONS*DATA_W-1:0]   i_s_rdata;

  modport slave (
    input  i_valid, i_addr, i_wdata, i_wren, i_mask,
    input  i_s_ready, i_s_rvalid, i_s_rdata,
    output o_ready, o_rvalid, o_rdata, o_err,
    output o_s_valid, o_s_addr, o_s_wdata, o_s_wren, o_s_mask
  );

  modport master (
    output i_valid, i_addr, i_wdata, i_wren, i_mask,
    output i_s_ready, i_s_rvalid, i_s_rdata,
    input  o_ready, o_rvalid, o_rdata, o_err,
    input  o_s_valid, o_s_addr, o_s_wdata, o_s_wren, o_s_mask
  );

endinterface

// File: rtl/mem_bus_router_decode.sv
// Combinational address window decoder: one-hot hit with lowest-index
// priority and a miss flag. A zero-sized window never hits.
module mem_region_decode
  import mem_bus_pkg::*;
#(
  parameter int N_REGIONS = 2
) (
  input  logic [ADDR_W-1:0]           addr,
  input  logic [N_REGIONS*ADDR_W-1:0] bases,
  input  logic [N_REGIONS*ADDR_W-1:0] sizes,
  output logic [N_REGIONS-1:0]        hit,
  output logic                        miss
);

  logic [ADDR_W-1:0] diff;
  logic              found;

  // Offset compare on the 30-bit difference avoids base+size overflow.
  always_comb begin
    hit   = '0;
    found = 1'b0;
    diff  = '0;
    for (int k = 0; k < N_REGIONS; k++) begin
      diff = addr - bases[k*ADDR_W +: ADDR_W];
      if (!found && (addr >= bases[k*ADDR_W +: ADDR_W]) &&
          (diff < sizes[k*ADDR_W +: ADDR_W])) begin
        hit[k] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = ~found;
  end

endmodule

// File: rtl/mem_bus_router.sv
// Routes CPU load/store requests to one of N_REGIONS slave windows with one
// outstanding transaction and a registered response.
// Build option: MEM_BUS_ROUTER_ERR_EN -- misses report o_err with ERR_RDATA;
// without it misses complete silently with zero data.
module mem_bus_router
  import mem_bus_pkg::*;
#(
  parameter int                            N_REGIONS   = 2,
  parameter logic [N_REGIONS*ADDR_W-1:0]   REGION_BASE = {30'h0400, 30'h0000},
  parameter logic [N_REGIONS*ADDR_W-1:0]   REGION_SIZE = {30'h0100, 30'h0400}
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  mem_bus_router_if.slave      bus
);

`ifdef MEM_BUS_ROUTER_ERR_EN
  localparam state_t            MISS_ST    = ST_ERR;
  localparam logic [DATA_W-1:0] MISS_RDATA = ERR_RDATA;
`else
  localparam state_t            MISS_ST    = ST_IDLE;
  localparam logic [DATA_W-1:0] MISS_RDATA = '0;
`endif

  state_t                      state, state_n;
  logic                        ready_c;
  logic                        accept;
  logic                        resp_done;
  logic [N_REGIONS-1:0]        hit;
  logic                        miss;

  logic [ADDR_W-1:0]           addr_q;
  logic [DATA_W-1:0]           wdata_q;
  logic                        wren_q;
  logic [3:0]                  mask_q;
  logic [N_REGIONS-1:0]        sel_q;
  logic                        rvalid_q;
  logic [DATA_W-1:0]           rdata_q;

  logic [DATA_W-1:0]           sel_rdata;
  logic [N_REGIONS*ADDR_W-1:0] s_addr;

  mem_region_decode #(
    .N_REGIONS (N_REGIONS)
  ) u_decode (
    .addr  (bus.i_addr),
    .bases (REGION_BASE),
    .sizes (REGION_SIZE),
    .hit   (hit),
    .miss  (miss)
  );

  // State register; reset abandons any in-flight slave transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next state and handshake control. ERR accepts like IDLE so the error
  // response and the next request can overlap.
  always_comb begin
    state_n   = state;
    ready_c   = 1'b0;
    accept    = 1'b0;
    resp_done = 1'b0;
    case (state)
      ST_IDLE, ST_ERR: begin
        ready_c = 1'b1;
        state_n = ST_IDLE;
        if (bus.i_valid) begin
          accept  = 1'b1;
          state_n = miss ? MISS_ST : ST_REQ;
        end
      end
      ST_REQ: begin
        if (|(bus.i_s_ready & sel_q)) begin
          if (|(bus.i_s_rvalid & sel_q)) begin
            resp_done = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            state_n   = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (|(bus.i_s_rvalid & sel_q)) begin
          resp_done = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // One-hot read-data mux from the selected slave.
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_REGIONS; k++) begin
      if (sel_q[k]) sel_rdata = sel_rdata | bus.i_s_rdata[k*DATA_W +: DATA_W];
    end
  end

  // Per-slave offset address from the captured request.
  always_comb begin
    s_addr = '0;
    for (int k = 0; k < N_REGIONS; k++) begin
      s_addr[k*ADDR_W +: ADDR_W] = addr_q - REGION_BASE[k*ADDR_W +: ADDR_W];
    end
  end

  // Request capture and registered response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wren_q   <= 1'b0;
      mask_q   <= '0;
      sel_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (accept) begin
        addr_q  <= bus.i_addr;
        wdata_q <= bus.i_wdata;
        wren_q  <= bus.i_wren;
        mask_q  <= bus.i_mask;
        sel_q   <= hit;
      end
      if (resp_done) begin
        rvalid_q <= 1'b1;
        rdata_q  <= wren_q ? '0 : sel_rdata;
      end else if (accept && miss) begin
        rvalid_q <= 1'b1;
        rdata_q  <= MISS_RDATA;
      end
    end
  end

`ifdef MEM_BUS_ROUTER_ERR_EN
  logic err_q;

  // Error flag accompanies the miss response strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= accept & miss;
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_ready   = ready_c;
  assign bus.o_rvalid  = rvalid_q;
  assign bus.o_rdata   = rdata_q;
  assign bus.o_s_valid = (state == ST_REQ) ? sel_q : '0;
  assign bus.o_s_addr  = s_addr;
  assign bus.o_s_wdata = wdata_q;
  assign bus.o_s_wren  = wren_q;
  assign bus.o_s_mask  = mask_q;

endmodule

// File: tb/tb_mem_bus_router.sv
// Randomized bench for mem_bus_router against a window-table reference model,
// plus a second instance with overlapping windows.
module tb_mem_bus_router;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

`ifdef MEM_BUS_ROUTER_ERR_EN
  localparam logic [31:0] EXP_MISS_RDATA = 32'hDEAD_BEEF;
  localparam logic        EXP_MISS_ERR   = 1'b1;
`else
  localparam logic [31:0] EXP_MISS_RDATA = 32'h0;
  localparam logic        EXP_MISS_ERR   = 1'b0;
`endif

  // Window table of the default instance: region 0 = [0,0x400), region 1 = [0x400,0x500).
  longint unsigned ref_base [2] = '{64'h0, 64'h400};
  longint unsigned ref_size [2] = '{64'h400, 64'h100};

  mem_bus_router_if #(.N_REGIONS(2)) bus0 ();
  mem_bus_router_if #(.N_REGIONS(2)) bus1 ();

  mem_bus_router dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus0)
  );

  mem_bus_router #(
    .N_REGIONS   (2),
    .REGION_BASE ({30'h0400, 30'h0000}),
    .REGION_SIZE ({30'h0100, 30'h0800})
  ) dut_ov (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_region(input logic [29:0] a);
    longint unsigned av;
    av = 64'(a);
    for (int k = 0; k < 2; k++) begin
      if (av >= ref_base[k] && av < ref_base[k] + ref_size[k]) return k;
    end
    return -1;
  endfunction

  // One complete transaction on bus0, starting and ending at a falling edge.
  // rd = cycles of ready delay, rv = cycles from handshake to rvalid (0 = same cycle).
  task automatic do_txn(input logic [29:0] a, input logic [31:0] wd, input logic we,
                        input logic [3:0] m, input int rd, input int rv, input logic [31:0] sd);
    int          k;
    logic [1:0]  exp_sv;
    logic [29:0] exp_off;
    k = ref_region(a);
    check_eq("ready_before_req", 64'(bus0.o_ready), 64'(1'b1));
    bus0.i_valid = 1'b1;
    bus0.i_addr  = a;
    bus0.i_wdata = wd;
    bus0.i_wren  = we;
    bus0.i_mask  = m;
    @(posedge clk);
    #1;
    bus0.i_valid = 1'b0;
    bus0.i_addr  = 30'($urandom);
    bus0.i_wdata = $urandom;
    bus0.i_wren  = 1'($urandom);
    bus0.i_mask  = 4'($urandom);
    @(negedge clk);
    if (k < 0) begin
      check_eq("miss_rvalid", 64'(bus0.o_rvalid), 64'(1'b1));
      check_eq("miss_rdata", 64'(bus0.o_rdata), 64'(EXP_MISS_RDATA));
      check_eq("miss_err", 64'(bus0.o_err), 64'(EXP_MISS_ERR));
      check_eq("miss_s_valid", 64'(bus0.o_s_valid), 64'(2'b00));
      check_eq("miss_ready", 64'(bus0.o_ready), 64'(1'b1));
    end else begin
      exp_sv    = '0;
      exp_sv[k] = 1'b1;
      exp_off   = 30'(64'(a) - ref_base[k]);
      for (int c = 0; c <= rd; c++) begin
        check_eq("req_s_valid", 64'(bus0.o_s_valid), 64'(exp_sv));
        check_eq("req_s_addr", 64'(bus0.o_s_addr[k*30 +: 30]), 64'(exp_off));
        check_eq("req_s_wdata", 64'(bus0.o_s_wdata), 64'(wd));
        check_eq("req_s_wren", 64'(bus0.o_s_wren), 64'(we));
        check_eq("req_s_mask", 64'(bus0.o_s_mask), 64'(m));
        check_eq("req_rvalid_low", 64'(bus0.o_rvalid), 64'(1'b0));
        bus0.i_s_ready      = 2'($urandom);
        bus0.i_s_ready[k]   = (c == rd);
        bus0.i_s_rvalid     = '0;
        bus0.i_s_rdata      = {$urandom, $urandom};
        if (c == rd && rv == 0) begin
          bus0.i_s_rvalid[k]          = 1'b1;
          bus0.i_s_rdata[k*32 +: 32]  = sd;
        end
        @(negedge clk);
      end
      for (int c = 1; c <= rv; c++) begin
        bus0.i_s_ready  = '0;
        check_eq("resp_s_valid", 64'(bus0.o_s_valid), 64'(2'b00));
        check_eq("resp_ready_low", 64'(bus0.o_ready), 64'(1'b0));
        check_eq("resp_rvalid_low", 64'(bus0.o_rvalid), 64'(1'b0));
        bus0.i_s_rvalid    = '0;
        bus0.i_s_rvalid[1-k] = 1'($urandom);
        bus0.i_s_rdata     = {$urandom, $urandom};
        if (c == rv) begin
          bus0.i_s_rvalid[k]         = 1'b1;
          bus0.i_s_rdata[k*32 +: 32] = sd;
        end
        @(negedge clk);
      end
      bus0.i_s_ready  = '0;
      bus0.i_s_rvalid = '0;
      check_eq("rsp_rvalid", 64'(bus0.o_rvalid), 64'(1'b1));
      check_eq("rsp_rdata", 64'(bus0.o_rdata), 64'(we ? 32'h0 : sd));
      check_eq("rsp_err", 64'(bus0.o_err), 64'(1'b0));
      check_eq("rsp_ready", 64'(bus0.o_ready), 64'(1'b1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [29:0] a;
    logic [29:0] edges [6];
    n_cmp = 0;
    n_mis = 0;
    edges = '{30'h0, 30'h3FF, 30'h400, 30'h4FF, 30'h500, 30'h3FFF_FFFF};
    rst_n = 1'b0;
    bus0.i_valid = 1'b0; bus0.i_addr = '0; bus0.i_wdata = '0; bus0.i_wren = 1'b0;
    bus0.i_mask = '0; bus0.i_s_ready = '0; bus0.i_s_rvalid = '0; bus0.i_s_rdata = '0;
    bus1.i_valid = 1'b0; bus1.i_addr = '0; bus1.i_wdata = '0; bus1.i_wren = 1'b0;
    bus1.i_mask = '0; bus1.i_s_ready = '0; bus1.i_s_rvalid = '0; bus1.i_s_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", 64'(bus0.o_ready), 64'(1'b1));
    check_eq("rst_rvalid", 64'(bus0.o_rvalid), 64'(1'b0));
    check_eq("rst_rdata", 64'(bus0.o_rdata), 64'(32'h0));
    check_eq("rst_err", 64'(bus0.o_err), 64'(1'b0));
    check_eq("rst_s_valid", 64'(bus0.o_s_valid), 64'(2'b00));
    check_eq("rst_s_addr1", 64'(bus0.o_s_addr[59:30]), 64'(30'h3FFF_FC00));
    check_eq("rst_s_wdata", 64'(bus0.o_s_wdata), 64'(32'h0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_txn(30'h0010, 32'h0, 1'b0, 4'hF, 0, 1, 32'h1234_5678);
    do_txn(30'h0402, 32'hCAFE_F00D, 1'b1, 4'b0011, 3, 1, 32'h5555_AAAA);
    do_txn(30'h0600, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0);
    do_txn(30'h03FF, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0BAD_0001);
    do_txn(30'h0400, 32'h0, 1'b0, 4'hF, 1, 2, 32'h0BAD_0002);
    do_txn(30'h3FFF_FFFF, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0);
    @(negedge clk);
    check_eq("idle_rvalid_low", 64'(bus0.o_rvalid), 64'(1'b0));

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 30'($urandom_range(0, 'h3FF));
        1:       a = 30'($urandom_range('h400, 'h4FF));
        2:       a = 30'($urandom_range('h500, 'hFFFF));
        3:       a = 30'($urandom);
        default: a = edges[$urandom_range(0, 5)];
      endcase
      do_txn(a, $urandom, 1'($urandom), 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        check_eq("gap_rvalid_low", 64'(bus0.o_rvalid), 64'(1'b0));
      end
    end

    // Reset while the slave request is pending.
    bus0.i_valid = 1'b1; bus0.i_addr = 30'h0010; bus0.i_wren = 1'b0;
    @(posedge clk);
    #1 bus0.i_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_s_valid", 64'(bus0.o_s_valid), 64'(2'b01));
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req_s_valid", 64'(bus0.o_s_valid), 64'(2'b00));
    check_eq("rst_req_ready", 64'(bus0.o_ready), 64'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while waiting for the slave response, then a late strobe.
    bus0.i_valid = 1'b1; bus0.i_addr = 30'h0020; bus0.i_wren = 1'b0;
    @(posedge clk);
    #1 bus0.i_valid = 1'b0;
    @(negedge clk);
    bus0.i_s_ready = 2'b01;
    @(negedge clk);
    bus0.i_s_ready = '0;
    check_eq("pre_rst_resp_ready", 64'(bus0.o_ready), 64'(1'b0));
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_resp_ready", 64'(bus0.o_ready), 64'(1'b1));
    check_eq("rst_resp_s_valid", 64'(bus0.o_s_valid), 64'(2'b00));
    check_eq("rst_resp_rvalid", 64'(bus0.o_rvalid), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    bus0.i_s_rvalid = 2'b01;
    bus0.i_s_rdata  = {32'h0, 32'h7777_7777};
    @(negedge clk);
    bus0.i_s_rvalid = '0;
    check_eq("late_rvalid_ignored", 64'(bus0.o_rvalid), 64'(1'b0));
    do_txn(30'h0030, 32'h0, 1'b0, 4'hF, 0, 1, 32'h2468_ACE0);

    // Overlapping windows: 0x400 lies in both, region 0 must win.
    bus1.i_valid = 1'b1; bus1.i_addr = 30'h0400; bus1.i_wren = 1'b0; bus1.i_mask = 4'hF;
    @(posedge clk);
    #1 bus1.i_valid = 1'b0;
    @(negedge clk);
    check_eq("ov_s_valid", 64'(bus1.o_s_valid), 64'(2'b01));
    check_eq("ov_s_addr0", 64'(bus1.o_s_addr[29:0]), 64'(30'h0400));
    bus1.i_s_ready  = 2'b01;
    bus1.i_s_rvalid = 2'b01;
    bus1.i_s_rdata  = {32'hFFFF_FFFF, 32'h0000_0A0A};
    @(negedge clk);
    bus1.i_s_ready  = '0;
    bus1.i_s_rvalid = '0;
    check_eq("ov_rvalid", 64'(bus1.o_rvalid), 64'(1'b1));
    check_eq("ov_rdata", 64'(bus1.o_rdata), 64'(32'h0000_0A0A));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
